// File: rtl/load_store_unit_pkg.sv
// Shared types and default sizing for the load/store unit: FSM state encoding,
// opcode values and datapath parameter defaults.
package load_store_unit_pkg;

    localparam int DATA_W_DEF    = 64;
    localparam int NREG_DEF      = 32;
    localparam int MEM_DEPTH_DEF = 64;
    localparam int OFF_W_DEF     = 5;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WB     = 3'd3,
        ST_DONE   = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_regfile.sv
// Register file for the load/store unit: three combinational read ports
// (base, source, debug), one write port, all entries cleared on reset.
module load_store_unit_regfile
#(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] base_ra_i,
    output logic [DATA_W-1:0] base_rd_o,
    input  logic [REG_AW-1:0] src_ra_i,
    output logic [DATA_W-1:0] src_rd_o,
    input  logic [REG_AW-1:0] dbg_ra_i,
    output logic [DATA_W-1:0] dbg_rd_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign base_rd_o = regs_q[base_ra_i];
    assign src_rd_o  = regs_q[src_ra_i];
    assign dbg_rd_o  = regs_q[dbg_ra_i];

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: base +/- offset addressing into a local data
// memory, with range checking and a host preload port for the register file.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int OFF_W     = OFF_W_DEF,
    localparam int REG_AW   = $clog2(NREG),
    localparam int MEM_AW   = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic              sub,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [OFF_W-1:0]  offset,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_wa,
    input  logic [DATA_W-1:0] host_wd,
    input  logic [REG_AW-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_rd,
    output lsu_state_e        dbg_state
);

    // Handshake: start is taken only while busy=0 (IDLE); each accepted start
    // yields exactly one done pulse, with err valid alongside it and held
    // until the next accepted start. A start seen while busy is dropped.

    lsu_state_e        state_q, state_d;
    logic              op_q, op_d;
    logic              sub_q, sub_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] base_rd, src_rd;
    logic [DATA_W:0]   eff;
    logic [DATA_W:0]   off_ext;
    logic              addr_err;
    logic              mem_we, wb_we, host_ok;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    load_store_unit_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_ra_i (rs_q),
        .base_rd_o (base_rd),
        .src_ra_i  (rt_q),
        .src_rd_o  (src_rd),
        .dbg_ra_i  (dbg_ra),
        .dbg_rd_o  (dbg_rd),
        .we_i      (rf_we),
        .wa_i      (rf_wa),
        .wd_i      (rf_wd)
    );

    // One extra bit catches both the carry of an add and the borrow of a subtract.
    assign off_ext  = (DATA_W+1)'(offset_q);
    assign eff      = sub_q ? ({1'b0, base_rd} - off_ext) : ({1'b0, base_rd} + off_ext);
    assign addr_err = eff[DATA_W] || (eff[DATA_W-1:0] >= DATA_W'(MEM_DEPTH));

    // Host writes only land while idle; WB never overlaps with IDLE.
    assign host_ok = host_we && (state_q == ST_IDLE);
    assign rf_we   = wb_we || host_ok;
    assign rf_wa   = wb_we ? rt_q : host_wa;
    assign rf_wd   = wb_we ? rdata_q : host_wd;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sub_d    = sub_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        wb_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sub_d    = sub;
                    rs_d     = rs;
                    rt_d     = rt;
                    offset_d = offset;
                    err_d    = 1'b0;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                wdata_d = src_rd;
                if (addr_err) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = eff[MEM_AW-1:0];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (op_q == OP_STORE) begin
                    mem_we  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                wb_we   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            sub_q    <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sub_q    <= sub_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // Data memory is intentionally not reset; the load read is registered.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
        if ((state_q == ST_ACCESS) && (op_q == OP_LOAD)) begin
            rdata_q <= mem_q[addr_q];
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized and directed LD/ST traffic checked
// against a register/memory array model, with a done-driven scoreboard monitor.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam int MD = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start   = 1'b0;
    logic          op      = 1'b0;
    logic          sub     = 1'b0;
    logic [4:0]    rs      = '0;
    logic [4:0]    rt      = '0;
    logic [4:0]    offset  = '0;
    logic          host_we = 1'b0;
    logic [4:0]    host_wa = '0;
    logic [DW-1:0] host_wd = '0;
    logic [4:0]    dbg_ra  = '0;
    logic          busy, done, err;
    logic [DW-1:0] dbg_rd;
    lsu_state_e    dbg_state;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .sub       (sub),
        .rs        (rs),
        .rt        (rt),
        .offset    (offset),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .host_we   (host_we),
        .host_wa   (host_wa),
        .host_wd   (host_wd),
        .dbg_ra    (dbg_ra),
        .dbg_rd    (dbg_rd),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_reg [NR];
    logic [DW-1:0] ref_mem [MD];
    logic [32:0]   exp_q[$];   // {err, cycle count at which done is expected}

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Applies one operation to the model; returns error flag and edge latency.
    task automatic model_op(input logic o, input logic s, input int rs_a, input int rt_a,
                            input int off, output logic e, output int lat);
        logic [DW-1:0] base, ea, off64;
        int addr;
        base  = ref_reg[rs_a];
        off64 = DW'(off);
        ea    = '0;
        if (s) begin
            e = (base < off64) || ((base - off64) >= DW'(MD));
            if (!e) ea = base - off64;
        end else begin
            e = (base >= DW'(MD)) || ((base + off64) >= DW'(MD));
            if (!e) ea = base + off64;
        end
        addr = int'(ea[6:0]);
        if (!e) begin
            if (o) ref_mem[addr] = ref_reg[rt_a];
            else   ref_reg[rt_a] = ref_mem[addr];
        end
        lat = e ? 2 : (o ? 3 : 4);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (rst_n && done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: got done=1 expected no done (cyc %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                if (err !== e[32] || cyc !== int'(e[31:0]) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL done_check: got err=%0b cyc=%0d busy=%0b expected err=%0b cyc=%0d busy=1",
                             err, cyc, busy, e[32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic host_wr(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        host_we = 1'b1;
        host_wa = 5'(a);
        host_wd = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
        ref_reg[a] = d;
    endtask

    task automatic issue_op(input logic o, input logic s, input int rs_a, input int rt_a, input int off,
                            input logic hw_en, input int hw_a, input logic [DW-1:0] hw_d);
        logic e;
        int lat;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        sub     = s;
        rs      = 5'(rs_a);
        rt      = 5'(rt_a);
        offset  = 5'(off);
        host_we = hw_en;
        host_wa = 5'(hw_a);
        host_wd = hw_d;
        if (hw_en) ref_reg[hw_a] = hw_d;
        model_op(o, s, rs_a, rt_a, off, e, lat);
        @(posedge clk);
        #1;
        start   = 1'b0;
        host_we = 1'b0;
        exp_q.push_back({e, 32'(cyc + lat - 1)});
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles (cyc %0d)", cyc);
        end
    endtask

    task automatic do_op(input logic o, input logic s, input int rs_a, input int rt_a, input int off);
        issue_op(o, s, rs_a, rt_a, off, 1'b0, 0, '0);
        wait_done();
    endtask

    task automatic check_reg(input int r);
        dbg_ra = 5'(r);
        #1;
        chk($sformatf("reg%0d", r), dbg_rd, ref_reg[r]);
    endtask

    task automatic check_all_regs();
        for (int r = 0; r < NR; r++) check_reg(r);
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic e;
        int lat;
        int rs_a, rt_a;
        for (int r = 0; r < NR; r++) ref_reg[r] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_err",  DW'(err),  '0);
        check_reg(0);
        check_reg(31);
        rst_n = 1'b1;

        // Fill memory through the DUT so the model knows every word
        for (int a = 0; a < MD; a++) begin
            host_wr(2, DW'(a));
            host_wr(3, {$urandom, $urandom});
            do_op(OP_STORE, 1'b0, 2, 3, 0);
        end

        // 1: basic store then load through addr 7
        host_wr(0, 64'd32);
        host_wr(1, 64'd0);
        do_op(OP_STORE, 1'b0, 1, 0, 7);
        do_op(OP_LOAD, 1'b0, 1, 12, 7);
        check_reg(12);
        chk("t1_r12_32", ref_reg[12], 64'd32);

        // 2: subtract addressing
        host_wr(2, 64'd10);
        host_wr(3, 64'hDEAD);
        do_op(OP_STORE, 1'b1, 2, 3, 3);
        do_op(OP_LOAD, 1'b0, 1, 4, 7);
        check_reg(4);

        // 3: out-of-range and borrow errors, err held afterwards
        host_wr(5, 64'd60);
        host_wr(9, 64'h1111);
        do_op(OP_LOAD, 1'b0, 5, 9, 4);
        check_reg(9);
        @(negedge clk);
        chk("err_hold", DW'(err), 64'd1);
        do_op(OP_LOAD, 1'b1, 1, 9, 1);
        check_reg(9);
        do_op(OP_LOAD, 1'b0, 5, 9, 3);
        check_reg(9);
        chk("err_clear", DW'(err), '0);

        // 4: start and host write while busy are ignored
        host_wr(8, 64'd5);
        issue_op(OP_STORE, 1'b0, 8, 8, 0, 1'b0, 0, '0);
        @(negedge clk);
        start = 1'b1; op = OP_LOAD; rs = 5'd8; rt = 5'd9; offset = 5'd1;
        host_we = 1'b1; host_wa = 5'd9; host_wd = 64'h1234;
        @(negedge clk);
        start = 1'b0; host_we = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("t4_idle", DW'(busy), '0);
        check_reg(9);

        // Host write coincident with start: ADDR sees the new base
        host_wr(14, 64'd90);
        issue_op(OP_LOAD, 1'b0, 14, 15, 2, 1'b1, 14, 64'd40);
        wait_done();
        check_reg(15);
        check_reg(14);

        // 5: reset during a load's ACCESS
        issue_op(OP_LOAD, 1'b0, 1, 20, 7, 1'b0, 0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", DW'(busy), '0);
        chk("mid_rst_done", DW'(done), '0);
        chk("mid_rst_err",  DW'(err),  '0);
        exp_q.delete();
        for (int r = 0; r < NR; r++) ref_reg[r] = '0;
        check_all_regs();
        @(negedge clk);
        rst_n = 1'b1;
        host_wr(1, 64'd7);
        do_op(OP_LOAD, 1'b0, 1, 21, 0);
        check_reg(21);

        // 6: rs == rt load, and back-to-back with start held high
        host_wr(6, 64'h55);
        do_op(OP_STORE, 1'b0, 1, 6, 0);
        do_op(OP_LOAD, 1'b0, 1, 1, 0);
        check_reg(1);
        chk("t6_r1_55", ref_reg[1], 64'h55);

        host_wr(10, 64'd20);
        host_wr(11, {$urandom, $urandom});
        @(negedge clk);
        start = 1'b1; op = OP_STORE; sub = 1'b0; rs = 5'd10; rt = 5'd11; offset = 5'd1;
        model_op(OP_STORE, 1'b0, 10, 11, 1, e, lat);
        @(posedge clk);
        #1;
        exp_q.push_back({e, 32'(cyc + lat - 1)});
        wait_done();
        op = OP_LOAD; rt = 5'd13;
        model_op(OP_LOAD, 1'b0, 10, 13, 1, e, lat);
        exp_q.push_back({e, 32'(cyc + 2 + lat - 1)});
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        check_reg(13);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rs_a = $urandom_range(0, NR - 1);
            rt_a = $urandom_range(0, NR - 1);
            host_wr(rs_a, DW'($urandom_range(0, 80)));
            if ($urandom_range(0, 3) == 0)
                issue_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs_a, rt_a,
                         $urandom_range(0, 31), 1'b1, rs_a, DW'($urandom_range(0, 70)));
            else
                issue_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs_a, rt_a,
                         $urandom_range(0, 31), 1'b0, 0, '0);
            wait_done();
            check_reg(rt_a);
            if (i % 10 == 9) check_all_regs();
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
